// File: rtl/router_pkg.sv
// Shared types, field positions and small helpers for the router read arbiter.
package router_pkg;

    localparam int NPORT      = 3;
    localparam int DW         = 8;
    localparam int LEN_MSB    = 7;
    localparam int LEN_LSB    = 2;
    localparam int PW         = 2;
    localparam int REM_W      = 7;  // holds len + 1, up to 64
    localparam int SKID_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [PW-1:0] port;
    } skid_entry_t;

    function automatic logic [PW-1:0] next_port(input logic [PW-1:0] p);
        logic [PW-1:0] n;
        if (p >= 2'd2) begin
            n = 2'd0;
        end else begin
            n = p + 2'd1;
        end
        return n;
    endfunction

    // First requesting port at or after ptr, wrapping modulo NPORT.
    function automatic logic [PW-1:0] rr_pick(input logic [NPORT-1:0] req,
                                              input logic [PW-1:0]    ptr);
        logic [PW-1:0]    cand;
        logic [PW-1:0]    pick;
        logic             found;
        logic [NPORT-1:0] sh;
        cand  = ptr;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < NPORT; k++) begin
            sh = req >> cand;
            if (!found && sh[0]) begin
                pick  = cand;
                found = 1'b1;
            end else begin
                found = found;
            end
            cand = next_port(cand);
        end
        return pick;
    endfunction

    function automatic logic [NPORT-1:0] port_onehot(input logic [PW-1:0] p);
        logic [NPORT-1:0] one;
        one = {{(NPORT-1){1'b0}}, 1'b1};
        return one << p;
    endfunction

    function automatic logic [REM_W-1:0] hdr_remaining(input logic [DW-1:0] hdr);
        return {1'b0, hdr[LEN_MSB:LEN_LSB]} + 7'd1;
    endfunction

endpackage

// File: rtl/router_read_arbiter_if.sv
// Router-side read ports plus the merged downstream byte stream.
interface router_read_arbiter_if;
    import router_pkg::*;

    logic [NPORT-1:0] vld_in;
    logic [DW-1:0]    data_in_0;
    logic [DW-1:0]    data_in_1;
    logic [DW-1:0]    data_in_2;
    logic [NPORT-1:0] read_enb;
    logic [DW-1:0]    m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_sop;
    logic             m_eop;
    logic [PW-1:0]    m_port;
    logic             pkt_abort;

    modport master (
        input  vld_in, data_in_0, data_in_1, data_in_2, m_ready,
        output read_enb, m_data, m_valid, m_sop, m_eop, m_port, pkt_abort
    );

    modport slave (
        output vld_in, data_in_0, data_in_1, data_in_2, m_ready,
        input  read_enb, m_data, m_valid, m_sop, m_eop, m_port, pkt_abort
    );

endinterface

// File: rtl/router_out_skid.sv
// Two-entry output buffer of tagged bytes; its count feeds the arbiter's read credit.
module router_out_skid
    import router_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        push,
    input  skid_entry_t din,
    input  logic        pop,
    output skid_entry_t dout,
    output logic [1:0]  count
);

    skid_entry_t mem_r [SKID_DEPTH];
    logic        wr_ptr_r;
    logic        rd_ptr_r;
    logic [1:0]  count_r;
    logic        push_ok_s;
    logic        pop_ok_s;
    logic [1:0]  count_s;

    // Qualify push/pop against occupancy and compute the next count
    always_comb begin
        pop_ok_s  = pop & (count_r != 2'd0);
        push_ok_s = push & ((count_r != 2'd2) | pop_ok_s);
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_s = count_r + 2'd1;
            2'b01:   count_s = count_r - 2'd1;
            default: count_s = count_r;
        endcase
    end

    // Storage and pointers
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_r[0] <= '0;
            mem_r[1] <= '0;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= din;
            end
            wr_ptr_r <= wr_ptr_r ^ push_ok_s;
            rd_ptr_r <= rd_ptr_r ^ pop_ok_s;
            count_r  <= count_s;
        end
    end

    // Head is forced to zero when empty so stale tags never reach the sink
    assign dout  = (count_r != 2'd0) ? mem_r[rd_ptr_r] : '0;
    assign count = count_r;

endmodule

// File: rtl/router_read_arbiter.sv
// Packet-atomic round-robin drain of the three router output FIFOs into one byte stream.
module router_read_arbiter
    import router_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    router_read_arbiter_if.master bus
);

    arb_state_t       state_r;
    arb_state_t       state_s;
    logic [PW-1:0]    grant_r;
    logic [PW-1:0]    grant_s;
    logic [PW-1:0]    rr_ptr_r;
    logic [PW-1:0]    rr_ptr_s;
    logic [PW-1:0]    pick_s;
    logic [REM_W-1:0] remaining_r;
    logic [REM_W-1:0] remaining_s;
    logic             inflight_r;
    logic [PW-1:0]    infl_port_r;
    logic             infl_sop_r;
    logic             infl_eop_r;
    logic             tag_sop_s;
    logic             tag_eop_s;
    logic             abort_s;
    logic             abort_r;
    logic [NPORT-1:0] read_req_s;
    logic [NPORT-1:0] read_enb_s;
    logic [NPORT-1:0] gsh_s;
    logic [DW-1:0]    ret_data_s;
    logic [1:0]       count_s;
    logic             pop_s;
    logic             credit_ok_s;
    logic             any_req_s;
    logic             grant_vld_s;
    skid_entry_t      push_entry_s;
    skid_entry_t      head_s;

    // Select the byte returning for last cycle's read
    always_comb begin
        case (infl_port_r)
            2'd0:    ret_data_s = bus.data_in_0;
            2'd1:    ret_data_s = bus.data_in_1;
            2'd2:    ret_data_s = bus.data_in_2;
            default: ret_data_s = '0;
        endcase
    end

    // Read credit, request summary and round-robin candidate
    always_comb begin
        pop_s       = (count_s != 2'd0) & bus.m_ready;
        credit_ok_s = ({1'b0, count_s} + {2'b00, inflight_r}) < (3'd2 + {2'b00, pop_s});
        any_req_s   = |bus.vld_in;
        pick_s      = rr_pick(bus.vld_in, rr_ptr_r);
        gsh_s       = bus.vld_in >> grant_r;
        grant_vld_s = gsh_s[0];
    end

    // Arbiter next-state and read issue
    always_comb begin
        state_s     = state_r;
        grant_s     = grant_r;
        rr_ptr_s    = rr_ptr_r;
        remaining_s = remaining_r;
        read_req_s  = '0;
        tag_sop_s   = 1'b0;
        tag_eop_s   = 1'b0;
        abort_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (any_req_s && credit_ok_s) begin
                    read_req_s = port_onehot(pick_s);
                    grant_s    = pick_s;
                    rr_ptr_s   = next_port(pick_s);
                    tag_sop_s  = 1'b1;
                    state_s    = HDR;
                end else begin
                    state_s = IDLE;
                end
            end
            HDR: begin
                // Header byte is on data_in this cycle; the length sizes the rest
                remaining_s = hdr_remaining(ret_data_s);
                state_s     = BODY;
            end
            BODY: begin
                if (remaining_r == 7'd0) begin
                    state_s = IDLE;
                end else if (!grant_vld_s) begin
                    abort_s     = 1'b1;
                    remaining_s = 7'd0;
                    state_s     = IDLE;
                end else if (credit_ok_s) begin
                    read_req_s  = port_onehot(grant_r);
                    remaining_s = remaining_r - 7'd1;
                    tag_eop_s   = (remaining_r == 7'd1);
                    if (remaining_r == 7'd1) begin
                        state_s = IDLE;
                    end else begin
                        state_s = BODY;
                    end
                end else begin
                    state_s = BODY;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign read_enb_s = reset ? '0 : read_req_s;

    // State, pointer and in-flight read tracking
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= IDLE;
            grant_r     <= 2'd0;
            rr_ptr_r    <= 2'd0;
            remaining_r <= 7'd0;
            inflight_r  <= 1'b0;
            infl_port_r <= 2'd0;
            infl_sop_r  <= 1'b0;
            infl_eop_r  <= 1'b0;
            abort_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            grant_r     <= grant_s;
            rr_ptr_r    <= rr_ptr_s;
            remaining_r <= remaining_s;
            inflight_r  <= |read_enb_s;
            infl_port_r <= grant_s;
            infl_sop_r  <= tag_sop_s;
            infl_eop_r  <= tag_eop_s;
            abort_r     <= abort_s;
        end
    end

    assign push_entry_s = '{data: ret_data_s, sop: infl_sop_r, eop: infl_eop_r, port: infl_port_r};

    router_out_skid u_skid (
        .clock (clock),
        .reset (reset),
        .push  (inflight_r),
        .din   (push_entry_s),
        .pop   (pop_s),
        .dout  (head_s),
        .count (count_s)
    );

    assign bus.read_enb  = read_enb_s;
    assign bus.m_data    = head_s.data;
    assign bus.m_valid   = (count_s != 2'd0);
    assign bus.m_sop     = head_s.sop;
    assign bus.m_eop     = head_s.eop;
    assign bus.m_port    = head_s.port;
    assign bus.pkt_abort = abort_r;

endmodule

// File: tb/tb_router_read_arbiter.sv
// Directed bench: router FIFO model on the read side, transfer log on the sink side.
module tb_router_read_arbiter;
    import router_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    router_read_arbiter_if bus ();

    router_read_arbiter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    logic [7:0]  q0[$];
    logic [7:0]  q1[$];
    logic [7:0]  q2[$];
    logic [2:0]  kill   = 3'b000;
    logic [2:0]  rd_lat = 3'b000;
    skid_entry_t out_q[$];
    logic [2:0]  rd_hist[$];
    int          abort_cnt   = 0;
    int          vectors     = 0;
    int          miscompares = 0;

    // Router FIFO model: read in cycle t returns the byte in t+1
    always @(posedge clock) begin
        if (reset) begin
            bus.data_in_0 <= 8'd0;
            bus.data_in_1 <= 8'd0;
            bus.data_in_2 <= 8'd0;
        end else begin
            if (rd_lat[0] && q0.size() != 0) bus.data_in_0 <= q0.pop_front();
            if (rd_lat[1] && q1.size() != 0) bus.data_in_1 <= q1.pop_front();
            if (rd_lat[2] && q2.size() != 0) bus.data_in_2 <= q2.pop_front();
        end
        bus.vld_in <= {(q2.size() != 0) & ~kill[2], (q1.size() != 0) & ~kill[1], (q0.size() != 0) & ~kill[0]};
    end

    // Mid-cycle monitor of reads, transfers and abort pulses
    always @(negedge clock) begin
        rd_lat <= bus.read_enb;
        if (!reset) begin
            rd_hist.push_back(bus.read_enb);
            if (bus.m_valid && bus.m_ready)
                out_q.push_back('{data: bus.m_data, sop: bus.m_sop, eop: bus.m_eop, port: bus.m_port});
            abort_cnt <= abort_cnt + (bus.pkt_abort ? 1 : 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        q0.delete();
        q1.delete();
        q2.delete();
        kill = 3'b000;
        tick(2);
        reset = 1'b0;
    endtask

    function automatic logic [7:0] pkt_byte(input int port, input int len, input logic [7:0] base, input int k);
        logic [5:0] l6;
        logic [1:0] p2;
        logic [7:0] hdr;
        logic [7:0] par;
        l6  = 6'(len);
        p2  = 2'(port);
        hdr = {l6, p2};
        par = hdr;
        for (int j = 0; j < len; j++) par = par ^ (base + 8'(j));
        if (k == 0) return hdr;
        else if (k <= len) return base + 8'(k - 1);
        else return par;
    endfunction

    task automatic load(input int port, input int len, input logic [7:0] base);
        for (int k = 0; k < len + 2; k++) begin
            case (port)
                0: q0.push_back(pkt_byte(port, len, base, k));
                1: q1.push_back(pkt_byte(port, len, base, k));
                default: q2.push_back(pkt_byte(port, len, base, k));
            endcase
        end
    endtask

    // Compare nb logged bytes starting at 'at' with the expected packet
    task automatic check_pkt(input string tag, input int at, input int port, input int len,
                             input logic [7:0] base, input int nb);
        int bad = 0;
        skid_entry_t x;
        for (int k = 0; k < nb; k++) begin
            x.data = pkt_byte(port, len, base, k);
            x.sop  = (k == 0);
            x.eop  = (k == len + 1);
            x.port = 2'(port);
            if (at + k >= out_q.size()) bad++;
            else if (out_q[at + k] !== x) bad++;
        end
        check(tag, bad, 0);
    endtask

    function automatic int rd_count(input int from, input int port);
        int c = 0;
        for (int i = from; i < rd_hist.size(); i++) c += int'(rd_hist[i][port]);
        return c;
    endfunction

    initial begin
        int o, h, a0, f, cnt;
        logic [6:0] pat;
        bus.m_ready = 1'b1;
        tick(3);

        // Reset state
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_read_enb", bus.read_enb, 0);
        check("rst_m_data", bus.m_data, 0);
        check("rst_m_port", bus.m_port, 0);
        check("rst_m_sop", bus.m_sop, 0);
        check("rst_m_eop", bus.m_eop, 0);
        check("rst_pkt_abort", bus.pkt_abort, 0);
        reset = 1'b0;

        // Single packet, port 0, len 3
        o = out_q.size();
        h = rd_hist.size();
        load(0, 3, 8'h11);
        tick(12);
        check("single_nbytes", out_q.size() - o, 5);
        check("single_hdr", (out_q.size() > o) ? out_q[o].data : 8'hxx, 8'h0C);
        check_pkt("single_stream", o, 0, 3, 8'h11, 5);
        check("single_reads", rd_count(h, 0), 5);
        f = -1;
        for (int i = h; i < rd_hist.size(); i++) if (f < 0 && rd_hist[i][0]) f = i;
        pat = 7'd0;
        if (f >= 0 && f + 6 < rd_hist.size())
            for (int k = 0; k < 7; k++) pat = {pat[5:0], rd_hist[f + k][0]};
        check("single_read_gap", pat, 7'h5E);

        // Fairness: all ports busy, rr_ptr = 0
        do_reset();
        o = out_q.size();
        load(0, 2, 8'h20);
        load(1, 2, 8'h30);
        load(2, 2, 8'h40);
        load(0, 2, 8'h50);
        tick(40);
        check("fair_nbytes", out_q.size() - o, 16);
        check_pkt("fair_pkt0", o,      0, 2, 8'h20, 4);
        check_pkt("fair_pkt1", o + 4,  1, 2, 8'h30, 4);
        check_pkt("fair_pkt2", o + 8,  2, 2, 8'h40, 4);
        check_pkt("fair_pkt3", o + 12, 0, 2, 8'h50, 4);

        // Backpressure mid-packet
        do_reset();
        o = out_q.size();
        load(2, 8, 8'h60);
        tick(5);
        bus.m_ready = 1'b0;
        h = rd_hist.size();
        tick(10);
        cnt = rd_count(h, 2);
        check("bp_reads_bounded", (cnt <= 2), 1);
        check("bp_reads_stopped", rd_count(rd_hist.size() - 5, 2), 0);
        check("bp_m_valid", bus.m_valid, 1);
        check("bp_head", bus.m_data, 8'h60);
        bus.m_ready = 1'b1;
        #1;
        check("bp_resume", bus.read_enb, 3'b100);
        tick(20);
        check("bp_nbytes", out_q.size() - o, 10);
        check_pkt("bp_stream", o, 2, 8, 8'h60, 10);

        // Zero-length packet
        do_reset();
        o = out_q.size();
        h = rd_hist.size();
        load(1, 0, 8'h00);
        tick(10);
        check("zero_nbytes", out_q.size() - o, 2);
        check("zero_sop", (out_q.size() > o) ? out_q[o].sop : 1'bx, 1);
        check("zero_eop", (out_q.size() > o + 1) ? out_q[o + 1].eop : 1'bx, 1);
        check("zero_parity", (out_q.size() > o + 1) ? out_q[o + 1].data : 8'hxx, 8'h01);
        check("zero_reads", rd_count(h, 1), 2);

        // Abort: port 1 loses vld after two payload reads
        do_reset();
        o  = out_q.size();
        h  = rd_hist.size();
        a0 = abort_cnt;
        load(1, 6, 8'h70);
        load(2, 1, 8'h90);
        tick(4);
        kill = 3'b010;
        tick(20);
        check("abort_pulses", abort_cnt - a0, 1);
        check("abort_nbytes", out_q.size() - o, 6);
        check_pkt("abort_partial", o, 1, 6, 8'h70, 3);
        check_pkt("abort_next_p2", o + 3, 2, 1, 8'h90, 3);
        check("abort_reads_p1", rd_count(h, 1), 3);

        // Reset in BODY
        do_reset();
        load(0, 8, 8'hA0);
        tick(4);
        reset = 1'b1;
        q0.delete();
        tick(1);
        check("rstmid_read_enb", bus.read_enb, 0);
        check("rstmid_m_valid", bus.m_valid, 0);
        check("rstmid_pkt_abort", bus.pkt_abort, 0);
        tick(1);
        reset = 1'b0;
        o = out_q.size();
        load(1, 1, 8'hB0);
        load(0, 1, 8'hC0);
        tick(15);
        check("rstmid_first_port", (out_q.size() > o) ? out_q[o].port : 2'bxx, 0);
        check_pkt("rstmid_pkt_p0", o,     0, 1, 8'hC0, 3);
        check_pkt("rstmid_pkt_p1", o + 3, 1, 1, 8'hB0, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
